// File: rtl/timestamp_pkg.sv
// Shared types and elaboration-time helpers for the timestamp capture reader.
package timestamp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SLO,
        SHI,
        HOLD,
        RSTC,
        WCLR
    } state_e;

    // Bits needed to count 0..value-1; never returns 0 so counters always exist.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/timestamp_reader_if.sv
// Valid/ready word stream carrying captured counts out of the reader.
interface timestamp_reader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, resets to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/timestamp_reader.sv
// SPI initiator that drains the timestamper capture latch on INT, hands the word
// out on a valid/ready stream, then pulses RSTCAPT until INT drops.
module timestamp_reader
    import timestamp_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SCLK_DIV    = 2,
    parameter int CLR_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic                  int_i,
    input  logic                  sdo_i,
    output logic                  sclk_o,
    output logic                  ce_n_o,
    output logic                  rstcapt_o,
    timestamp_reader_if.master    out_if
);
    localparam int BIT_W = clog2_min1(WIDTH + 1);
    localparam int MAX_C = (SCLK_DIV > CLR_TIMEOUT) ? SCLK_DIV : CLR_TIMEOUT;
    localparam int CNT_W = clog2_min1(MAX_C);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_TIMEOUT - 1);
    localparam logic [BIT_W-1:0] BITS     = BIT_W'(WIDTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              sclk_q, ce_n_q, rstcapt_q;
    logic              int_s;

    sync_2ff #(.WIDTH(1)) u_int_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (int_i),
        .q_o     (int_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (valid_q && out_if.ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_d = '0;
                cnt_d = '0;
                // An unconsumed word holds off the next read; INT just stays high.
                if (int_s && enable_i && !valid_q) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) state_d = SLO;
            end
            SLO: begin
                if (cnt_q == DIV_LAST) begin
                    shift_d = WIDTH'({shift_q, sdo_i});
                    state_d = SHI;
                end
            end
            SHI: begin
                if (cnt_q == DIV_LAST) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_d < BITS) begin
                        state_d = SLO;
                    end else begin
                        state_d = HOLD;
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) state_d = RSTC;
            end
            RSTC: begin
                if (cnt_q == DIV_LAST) state_d = WCLR;
            end
            WCLR: begin
                if (!int_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CLR_LAST) begin
                    state_d = RSTC;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Pin outputs are registered from the next state so they are glitch-free yet
    // change on the same edge as the state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sclk_q    <= 1'b0;
            ce_n_q    <= 1'b1;
            rstcapt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sclk_q    <= (state_d == SHI);
            ce_n_q    <= !((state_d == SETUP) || (state_d == SLO) || (state_d == SHI));
            rstcapt_q <= (state_d == RSTC);
        end
    end

    assign sclk_o       = sclk_q;
    assign ce_n_o       = ce_n_q;
    assign rstcapt_o    = rstcapt_q;
    assign out_if.data  = data_q;
    assign out_if.valid = valid_q;
endmodule
